pc_unit: RTL and testbench

//   Parametrised program-counter unit for the MIPS-style core; supersedes the plain pc register.

---
 rtl/pc_unit_pkg.sv | 25 ++
 rtl/pc_unit_if.sv | 36 +++
 rtl/pc_ras.sv | 54 +++++
 rtl/pc_unit.sv | 94 +++++++++
 tb/tb_pc_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_unit_pkg : next-PC select encodings and default geometry for pc_unit
// rev 1.0
// ---------------------------------------------------------------------------
package pc_unit_pkg;

  typedef logic [2:0] npc_op_t;

  localparam npc_op_t NPC_SEQ  = 3'd0;
  localparam npc_op_t NPC_BR   = 3'd1;
  localparam npc_op_t NPC_J    = 3'd2;
  localparam npc_op_t NPC_JR   = 3'd3;
  localparam npc_op_t NPC_CALL = 3'd4;
  localparam npc_op_t NPC_RET  = 3'd5;
  localparam npc_op_t NPC_RSVD = 3'd6;
  localparam npc_op_t NPC_ERET = 3'd7;

  localparam int          c_PC_W      = 30;
  localparam logic [29:0] c_RESET_PC  = 30'h0000_0C00;
  localparam logic [29:0] c_EXC_VEC   = 30'h0000_1060;
  localparam int          c_RAS_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_unit_if : control-unit <-> pc_unit signal bundle
// rev 1.0
// ---------------------------------------------------------------------------
interface pc_unit_if #(
  parameter int PC_W = 30
);
  import pc_unit_pkg::*;

  logic            stall;
  npc_op_t         npc_op;
  logic            br_taken;
  logic [15:0]     imm16;
  logic [25:0]     jidx;
  logic [PC_W-1:0] jr_target;
  logic            exc_req;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] epc;
  logic            ras_empty;
  logic            ras_full;
  logic            ret_mismatch;

  modport master (
    output stall, npc_op, br_taken, imm16, jidx, jr_target, exc_req,
    input  pc, pc_plus1, epc, ras_empty, ras_full, ret_mismatch
  );

  modport slave (
    input  stall, npc_op, br_taken, imm16, jidx, jr_target, exc_req,
    output pc, pc_plus1, epc, ras_empty, ras_full, ret_mismatch
  );

endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_ras : circular shadow return-address stack, oldest entry overwritten when full
// rev 1.0
// ---------------------------------------------------------------------------
module pc_ras #(
  parameter int W     = 30,
  parameter int DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         push,
  input  wire logic         pop,
  input  wire logic [W-1:0] din,
  output logic      [W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]    c_DEPTH = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_ptr_inc;

  assign w_ptr_inc = r_ptr + 1'b1;
  assign top       = r_mem[r_ptr];
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_DEPTH);

  // Pointer always advances on push; when full this lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= w_ptr_inc;
      if (!full) r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_ptr   <= r_ptr - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[w_ptr_inc] <= din;
  end

  a_no_push_pop : assert property (@(posedge clk) disable iff (rst) !(push && pop));

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_unit : word-address PC with next-PC select, stall, exception/EPC and shadow RAS
// rev 1.0
// ---------------------------------------------------------------------------
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W      = c_PC_W,
  parameter logic [PC_W-1:0] RESET_PC  = c_RESET_PC,
  parameter logic [PC_W-1:0] EXC_VEC   = c_EXC_VEC,
  parameter int              RAS_DEPTH = c_RAS_DEPTH
) (
  input wire logic clk,
  input wire logic rst,
  pc_unit_if.slave bus
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_epc;
  logic            r_mismatch;
  logic [PC_W-1:0] w_pc_plus1;
  logic [PC_W-1:0] w_offset;
  logic [PC_W-1:0] w_jtarget;
  logic [PC_W-1:0] w_npc;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_advance;
  logic            w_push;
  logic            w_pop;

  assign w_pc_plus1 = r_pc + 1'b1;
  assign w_offset   = {{(PC_W-16){bus.imm16[15]}}, bus.imm16};
  assign w_jtarget  = {w_pc_plus1[PC_W-1:26], bus.jidx};

  // The op only takes effect when neither an exception nor a stall preempts it.
  assign w_advance = !bus.exc_req && !bus.stall;
  assign w_push    = w_advance && (bus.npc_op == NPC_CALL);
  assign w_pop     = w_advance && (bus.npc_op == NPC_RET) && !w_ras_empty;

  always_comb begin
    w_npc = w_pc_plus1;
    case (bus.npc_op)
      NPC_BR:   if (bus.br_taken) w_npc = w_pc_plus1 + w_offset;
      NPC_J,
      NPC_CALL: w_npc = w_jtarget;
      NPC_JR,
      NPC_RET:  w_npc = bus.jr_target;
      NPC_ERET: w_npc = r_epc;
      default:  w_npc = w_pc_plus1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_epc      <= '0;
      r_mismatch <= 1'b0;
    end else if (bus.exc_req) begin
      r_pc       <= EXC_VEC;
      r_epc      <= r_pc;
      r_mismatch <= 1'b0;
    end else if (bus.stall) begin
      r_mismatch <= 1'b0;
    end else begin
      r_pc       <= w_npc;
      r_mismatch <= w_pop && (w_ras_top != bus.jr_target);
    end
  end

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_plus1),
    .top   (w_ras_top),
    .empty (w_ras_empty),
    .full  (w_ras_full)
  );

  assign bus.pc           = r_pc;
  assign bus.pc_plus1     = w_pc_plus1;
  assign bus.epc          = r_epc;
  assign bus.ras_empty    = w_ras_empty;
  assign bus.ras_full     = w_ras_full;
  assign bus.ret_mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_unit : scoreboard bench for pc_unit against a queue-based reference model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_unit;
  import pc_unit_pkg::*;

  typedef struct {
    logic [29:0] pc;
    logic [29:0] epc;
    bit          empty;
    bit          full;
    bit          mis;
  } exp_t;

  logic clk;
  logic rst;
  pc_unit_if #(.PC_W(30)) bus ();

  pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [29:0] m_pc;
  logic [29:0] m_epc;
  logic [29:0] m_ras[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  // Reference model: plain arithmetic on the architectural rules, RAS as a bounded queue.
  task automatic step(input bit r, input bit st, input bit ex, input logic [2:0] op,
                      input bit bt, input logic [15:0] imm, input logic [25:0] ji,
                      input logic [29:0] jr);
    exp_t               e;
    logic [29:0]        p1;
    logic signed [29:0] off;
    bit                 mis;
    @(negedge clk);
    rst           = r;
    bus.stall     = st;
    bus.exc_req   = ex;
    bus.npc_op    = op;
    bus.br_taken  = bt;
    bus.imm16     = imm;
    bus.jidx      = ji;
    bus.jr_target = jr;
    mis = 1'b0;
    p1  = m_pc + 30'd1;
    off = $signed(imm);
    if (r) begin
      m_pc = 30'h0000_0C00; m_epc = '0; m_ras.delete();
    end else if (ex) begin
      m_epc = m_pc; m_pc = 30'h0000_1060;
    end else if (!st) begin
      case (op)
        3'd1: m_pc = bt ? p1 + 30'(off) : p1;
        3'd2: m_pc = {p1[29:26], ji};
        3'd3: m_pc = jr;
        3'd4: begin
          m_pc = {p1[29:26], ji};
          m_ras.push_back(p1);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
        3'd5: begin
          m_pc = jr;
          if (m_ras.size() > 0) mis = (m_ras.pop_back() != jr);
        end
        3'd7: m_pc = m_epc;
        default: m_pc = p1;
      endcase
    end
    e.pc = m_pc; e.epc = m_epc; e.mis = mis;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == 4);
    q.push_back(e);
  endtask

  task automatic op(input logic [2:0] o, input logic [25:0] ji, input logic [29:0] jr);
    step(1'b0, 1'b0, 1'b0, o, 1'b0, 16'h0, ji, jr);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",           {2'b0, bus.pc},       {2'b0, e.pc});
        chk("pc_plus1",     {2'b0, bus.pc_plus1}, {2'b0, e.pc + 30'd1});
        chk("epc",          {2'b0, bus.epc},      {2'b0, e.epc});
        chk("ras_empty",    {31'b0, bus.ras_empty},    {31'b0, e.empty});
        chk("ras_full",     {31'b0, bus.ras_full},     {31'b0, e.full});
        chk("ret_mismatch", {31'b0, bus.ret_mismatch}, {31'b0, e.mis});
      end
    end
  end

  initial begin : driver
    logic [29:0] jr;
    rst = 1'b1; bus.stall = 1'b0; bus.exc_req = 1'b0; bus.npc_op = NPC_SEQ;
    bus.br_taken = 1'b0; bus.imm16 = '0; bus.jidx = '0; bus.jr_target = '0;
    m_pc = '0; m_epc = '0;

    step(1, 0, 0, NPC_SEQ, 0, 0, 0, 0);
    step(1, 0, 0, NPC_SEQ, 0, 0, 0, 0);
    repeat (3) op(NPC_SEQ, 0, 0);

    op(NPC_JR, 0, 30'hC05);
    step(0, 0, 0, NPC_BR, 1, 16'hFFFE, 0, 0);
    op(NPC_JR, 0, 30'hC05);
    step(0, 0, 0, NPC_BR, 0, 16'hFFFE, 0, 0);

    op(NPC_JR, 0, 30'hC10);
    op(NPC_CALL, 26'h100, 0);
    op(NPC_RET, 0, 30'hC11);
    op(NPC_JR, 0, 30'hC10);
    op(NPC_CALL, 26'h100, 0);
    op(NPC_RET, 0, 30'hC20);
    op(NPC_SEQ, 0, 0);

    for (int i = 0; i < 5; i++) op(NPC_CALL, 26'h200 + 26'(i * 16), 0);
    for (int i = 0; i < 5; i++) begin
      jr = (m_ras.size() > 0) ? m_ras[$] : 30'h123;
      op(NPC_RET, 0, jr);
    end

    op(NPC_JR, 0, 30'hC08);
    step(0, 1, 1, NPC_SEQ, 0, 0, 0, 0);
    repeat (2) op(NPC_SEQ, 0, 0);
    op(NPC_ERET, 0, 0);

    op(NPC_JR, 0, 30'h3FFF_FFFF);
    op(NPC_SEQ, 0, 0);
    op(NPC_CALL, 26'h40, 0);
    step(0, 1, 0, NPC_CALL, 0, 0, 26'h80, 0);
    step(1, 0, 0, NPC_RET, 0, 0, 0, 30'h41);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] o;
      o  = 3'($urandom_range(0, 7));
      jr = 30'($urandom());
      if (o == NPC_RET && m_ras.size() > 0 && $urandom_range(0, 1) == 1) jr = m_ras[$];
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0, o, 1'($urandom()), 16'($urandom()),
           26'($urandom()), jr);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
